// File: rtl/raminfr_pkg.sv
// Constants and types shared by the distributed RAM and its block-read engine.
package raminfr_pkg;
  localparam int RAM_AW = 5;
  localparam int RAM_DW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;
endpackage

// File: rtl/raminfr_rd_stream_if.sv
// Valid/ready word stream with a last-beat marker.
interface raminfr_rd_stream_if
  import raminfr_pkg::*;
#(
  parameter int DW = RAM_DW
) ();
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  modport master (output m_data, output m_valid, output m_last, input  m_ready);
  modport slave  (input  m_data, input  m_valid, input  m_last, output m_ready);
endinterface

// File: rtl/raminfr.sv
// Dual-port distributed RAM: synchronous write, combinational reads on both ports.
module raminfr
  import raminfr_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] di,
  input  logic [AW-1:0] dpra,
  output logic [DW-1:0] spo,
  output logic [DW-1:0] dpo
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[a] <= di;

  assign spo = mem[a];
  assign dpo = mem[dpra];
endmodule

// File: rtl/raminfr_rd_stream.sv
// Block-read engine: walks the RAM read port from base for len words and
// emits each registered word on a valid/ready stream with a last flag.
module raminfr_rd_stream
  import raminfr_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        base,
  input  logic [AW:0]          len,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        dpra,
  input  logic [DW-1:0]        dpo,
  raminfr_rd_stream_if.master  m
);
  rd_state_t     state;
  logic [AW-1:0] addr;
  logic [AW:0]   rem;
  logic [DW-1:0] data_q;
  logic          valid_q, last_q, done_q;
  logic          load, accept;

  // A new word may enter the output register when it is empty or draining.
  assign load   = (state == READ) && (rem != '0) && (!valid_q || m.m_ready);
  assign accept = valid_q && m.m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      rem     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          addr <= base;
          rem  <= len;
          if (len == '0) done_q <= 1'b1;
          else           state  <= READ;
        end
        READ: begin
          if (load) begin
            data_q  <= dpo;
            valid_q <= 1'b1;
            last_q  <= (rem == (AW+1)'(1));
            addr    <= addr + AW'(1);
            rem     <= rem - (AW+1)'(1);
          end else if (accept) begin
            valid_q <= 1'b0;
            // Last beat leaves with rem==0, so no load can race this branch.
            if (last_q) begin
              last_q <= 1'b0;
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dpra      = addr;
  assign busy      = (state == READ) || valid_q;
  assign done      = done_q;
  assign m.m_data  = data_q;
  assign m.m_valid = valid_q;
  assign m.m_last  = last_q;
endmodule

// File: tb/tb_raminfr_rd_stream.sv
// Scoreboard bench: RAM + read engine side by side, directed commands.
module tb_raminfr_rd_stream;
  import raminfr_pkg::*;
  localparam int AW = RAM_AW;
  localparam int DW = RAM_DW;

  logic          clk = 1'b0;
  logic          rst_n, start, we;
  logic [AW-1:0] base, a, dpra;
  logic [AW:0]   len;
  logic [DW-1:0] di, spo, dpo;
  logic          busy, done;

  raminfr_rd_stream_if #(.DW(DW)) vif ();

  raminfr #(.AW(AW), .DW(DW)) u_ram (
    .clk(clk), .we(we), .a(a), .di(di), .dpra(dpra), .spo(spo), .dpo(dpo)
  );

  raminfr_rd_stream #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .dpra(dpra), .dpo(dpo), .m(vif.master)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int beats  = 0;
  int cyc    = 0;
  logic [DW:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    we = 1'b1; a = ad; di = d;
    tick();
    we = 1'b0;
  endtask

  // Leaves the bench at cycle 1 of the command with start dropped.
  task automatic issue(input logic [AW-1:0] b, input logic [AW:0] l);
    start = 1'b1; base = b; len = l; cyc = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cyc);
    while (!done && cyc < 60) tick();
    chk(name, cyc, exp_cyc);
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && vif.m_valid && vif.m_ready) begin
      beats++;
      if (exp_q.size() == 0) chk("unexpected beat", {27'd0, vif.m_last, vif.m_data}, 32'hFFFF);
      else chk("beat", {27'd0, vif.m_last, vif.m_data}, {27'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int b0;
    rst_n = 1'b0; start = 1'b0; base = '0; len = '0;
    we = 1'b0; a = '0; di = '0; vif.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst m_valid", vif.m_valid, 0);
    chk("rst m_last",  vif.m_last,  0);
    chk("rst m_data",  vif.m_data,  0);
    chk("rst busy",    busy,        0);
    chk("rst done",    done,        0);
    chk("rst dpra",    dpra,        0);
    rst_n = 1'b1;
    tick();

    wr(1, 4'b1010); wr(2, 4'b1100); wr(3, 4'b0000);

    // Basic two-word read, ready held high.
    push(4'b1010, 0); push(4'b1100, 1); b0 = beats;
    issue(1, 2);
    chk("t1 dpra c1", dpra, 1);
    chk("t1 busy c1", busy, 1);
    chk("t1 valid c1", vif.m_valid, 0);
    tick();
    chk("t1 valid c2", vif.m_valid, 1);
    chk("t1 data c2", vif.m_data, 4'b1010);
    chk("t1 last c2", vif.m_last, 0);
    tick();
    chk("t1 data c3", vif.m_data, 4'b1100);
    chk("t1 last c3", vif.m_last, 1);
    tick();
    chk("t1 done c4", done, 1);
    chk("t1 busy c4", busy, 0);
    tick();
    chk("t1 done c5", done, 0);
    chk("t1 beats", beats - b0, 2);

    // Backpressure on the first beat for three cycles.
    vif.m_ready = 1'b0;
    push(4'b1010, 0); push(4'b1100, 1); b0 = beats;
    issue(1, 2);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t2 hold data", vif.m_data, 4'b1010);
      chk("t2 hold dpra", dpra, 2);
      chk("t2 hold valid", vif.m_valid, 1);
      tick();
    end
    vif.m_ready = 1'b1;
    wait_done("t2 done cycle", 7);
    chk("t2 beats", beats - b0, 2);
    tick();

    // Address wrap 30,31,0,1.
    wr(30, 4'b0001); wr(31, 4'b0010); wr(0, 4'b0011); wr(1, 4'b0100);
    push(4'b0001, 0); push(4'b0010, 0); push(4'b0011, 0); push(4'b0100, 1);
    b0 = beats;
    issue(30, 4);
    chk("t3 dpra c1", dpra, 30);
    tick();
    chk("t3 dpra c2", dpra, 31);
    tick();
    chk("t3 dpra wrap", dpra, 0);
    wait_done("t3 done cycle", 6);
    chk("t3 beats", beats - b0, 4);
    tick();

    // Zero-length command.
    issue(9, 0);
    chk("t4 done c1", done, 1);
    chk("t4 busy c1", busy, 0);
    chk("t4 valid c1", vif.m_valid, 0);
    tick();
    chk("t4 done c2", done, 0);
    chk("t4 busy c2", busy, 0);

    // Start while busy is ignored.
    push(4'b0100, 0); push(4'b1100, 1); b0 = beats;
    issue(1, 2);
    start = 1'b1; base = 5; len = 3;
    tick();
    start = 1'b0;
    chk("t4 ignore dpra", dpra, 2);
    wait_done("t4 ignore done", 4);
    repeat (3) tick();
    chk("t4 ignore beats", beats - b0, 2);
    chk("t4 ignore idle", vif.m_valid, 0);

    // Write/read collision on the load edge returns the old word.
    push(4'b0000, 1);
    issue(3, 1);
    we = 1'b1; a = 3; di = 4'b1111;
    tick();
    we = 1'b0;
    wait_done("t5 collide done", 3);
    tick();
    push(4'b1111, 1);
    issue(3, 1);
    wait_done("t5 reread done", 3);
    tick();

    // Reset during beat 2 of a four-word command.
    wr(4, 4'd5); wr(5, 4'd6); wr(6, 4'd7); wr(7, 4'd8);
    push(4'd5, 0);
    issue(4, 4);
    tick();
    tick();
    chk("t6 beat2 valid", vif.m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6 rst valid", vif.m_valid, 0);
    chk("t6 rst busy",  busy, 0);
    chk("t6 rst done",  done, 0);
    chk("t6 rst dpra",  dpra, 0);
    chk("t6 rst last",  vif.m_last, 0);
    chk("t6 queue empty", exp_q.size(), 0);
    tick();
    chk("t6 rst hold done", done, 0);
    rst_n = 1'b1;
    tick();
    chk("t6 post done", done, 0);
    push(4'd7, 0); push(4'd8, 1); b0 = beats;
    issue(6, 2);
    wait_done("t6 fresh done", 4);
    tick();
    chk("t6 fresh beats", beats - b0, 2);
    chk("final queue empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
